fetch_if_id_stage: RTL and testbench

//  Fetch stage of the 5-stage pipeline plus the IF/ID register in front of decode.
//  - Owns the PC and issues word fetches over a valid/ready imem port (one request outstanding).
//  - Holds the fetched word while decode stalls; flushes on jump/branch redirect.
//  - Presents the IF/ID instruction and its split fields (opcode/funct3/funct7/rs1/rs2/rd) to the control unit.

---
 rtl/fetch_if_id_stage.sv | 123 ++++++++++++
 tb/tb_fetch_if_id_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, issues one outstanding imem
// request at a time, buffers a returned word while decode stalls, and flushes on redirect.
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | request valid at pc, waiting for imem to accept
// WAIT  | request accepted, waiting for the response word
// HOLD  | response captured in skid buffer, waiting for decode to accept
// DROP  | redirect overtook an in-flight request; discard its response
module fetch_if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid;
  logic        handshake;
  logic        accept;
  logic        load_resp;
  logic        load_skid;

  assign imem_req_valid = (state == S_REQ) & ~rst;
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid & imem_req_ready;
  assign accept         = ~if_id_valid | ~id_stall;
  assign load_resp      = (state == S_WAIT) & imem_resp_valid & accept;
  assign load_skid      = (state == S_HOLD) & accept;

  assign opcode = if_id_instruction[6:0];
  assign rd     = if_id_instruction[11:7];
  assign funct3 = if_id_instruction[14:12];
  assign rs1    = if_id_instruction[19:15];
  assign rs2    = if_id_instruction[24:20];
  assign funct7 = if_id_instruction[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_REQ;
      pc                <= RESET_PC;
      skid              <= '0;
      if_id_valid       <= 1'b0;
      if_id_pc          <= '0;
      if_id_instruction <= NOP_INSTR;
    end else if (redirect_valid) begin
      pc                <= redirect_pc & ~32'h3;
      skid              <= '0;
      if_id_valid       <= 1'b0;
      if_id_pc          <= pc;
      if_id_instruction <= NOP_INSTR;
      // Any request still owed a response must have that response discarded.
      case (state)
        S_REQ:   state <= handshake ? S_DROP : S_REQ;
        S_WAIT:  state <= imem_resp_valid ? S_REQ : S_DROP;
        S_HOLD:  state <= S_REQ;
        default: state <= imem_resp_valid ? S_REQ : S_DROP;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (accept) begin
              pc    <= pc + 32'd4;
              state <= S_REQ;
            end else begin
              skid  <= imem_resp_data;
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (accept) begin
            skid  <= '0;
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        default: begin
          if (imem_resp_valid) state <= S_REQ;
        end
      endcase

      if (load_resp) begin
        if_id_valid       <= 1'b1;
        if_id_pc          <= pc;
        if_id_instruction <= imem_resp_data;
      end else if (load_skid) begin
        if_id_valid       <= 1'b1;
        if_id_pc          <= pc;
        if_id_instruction <= skid;
      end else if (accept) begin
        if_id_valid       <= 1'b0;
        if_id_instruction <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Directed bench for fetch_if_id_stage: a cycle-by-cycle vector table driving a
// hand-played 1-cycle imem, plus hand sequences for reset behaviour.
module tb_fetch_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  fetch_if_id_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_instruction(if_id_instruction),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] data;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt [28];
  int   checks = 0;
  int   errors = 0;
  int   cur    = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, cur, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] data,
                       input logic stall, input logic redir, input logic [31:0] rpc);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = data;
    id_stall        = stall;
    redirect_valid  = redir;
    redirect_pc     = rpc;
  endtask

  initial begin
    // T1: 1-cycle imem, one instruction every 2 cycles
    vt[0]  = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         NOP};
    vt[1]  = '{0, 1, 32'hA000_0001, 0, 0, 32'h0,         1, 32'h4,         1, 1, 32'h0,         32'hA000_0001};
    vt[2]  = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         0, 0, 32'h0,         NOP};
    vt[3]  = '{0, 1, 32'hA000_0002, 0, 0, 32'h0,         1, 32'h8,         1, 1, 32'h4,         32'hA000_0002};
    vt[4]  = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h8,         0, 0, 32'h0,         NOP};
    vt[5]  = '{0, 1, 32'hA000_0003, 0, 0, 32'h0,         1, 32'hC,         1, 1, 32'h8,         32'hA000_0003};
    vt[6]  = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'hC,         0, 0, 32'h0,         NOP};
    vt[7]  = '{0, 1, 32'hA000_0004, 0, 0, 32'h0,         1, 32'h10,        1, 1, 32'hC,         32'hA000_0004};
    // T2: stall while response arrives -> HOLD, release loads skid word
    vt[8]  = '{1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h10,        1, 1, 32'hC,         32'hA000_0004};
    vt[9]  = '{0, 1, 32'h00A0_0093, 1, 0, 32'h0,         0, 32'h10,        1, 1, 32'hC,         32'hA000_0004};
    vt[10] = '{0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h10,        1, 1, 32'hC,         32'hA000_0004};
    vt[11] = '{0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h14,        1, 1, 32'h10,        32'h00A0_0093};
    // T3: redirect in WAIT without response -> DROP swallows stale word
    vt[12] = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h14,        0, 0, 32'h0,         NOP};
    vt[13] = '{0, 0, 32'h0,         0, 1, 32'h103,       0, 32'h100,       0, 0, 32'h0,         NOP};
    vt[14] = '{0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 32'h100,       0, 0, 32'h0,         NOP};
    vt[15] = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h100,       0, 0, 32'h0,         NOP};
    vt[16] = '{0, 1, 32'h1111_1111, 0, 0, 32'h0,         1, 32'h104,       1, 1, 32'h100,       32'h1111_1111};
    // T4: redirect together with response -> straight to REQ at target
    vt[17] = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h104,       0, 0, 32'h0,         NOP};
    vt[18] = '{0, 1, 32'h2222_2222, 0, 1, 32'h200,       1, 32'h200,       0, 0, 32'h0,         NOP};
    vt[19] = '{0, 1, 32'h7777_7777, 0, 0, 32'h0,         1, 32'h200,       0, 0, 32'h0,         NOP};
    vt[20] = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h200,       0, 0, 32'h0,         NOP};
    vt[21] = '{0, 1, 32'h3333_3333, 0, 0, 32'h0,         1, 32'h204,       1, 1, 32'h200,       32'h3333_3333};
    // T5: PC wraps from FFFF_FFFC to 0
    vt[22] = '{0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         NOP};
    vt[23] = '{1, 0, 32'h0,         0, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 0, 32'h0,         NOP};
    vt[24] = '{0, 1, 32'h4444_4444, 0, 0, 32'h0,         1, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h4444_4444};
    // into HOLD with stall high, ready for the reset sequence
    vt[25] = '{1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h4444_4444};
    vt[26] = '{0, 1, 32'h5555_5555, 1, 0, 32'h0,         0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h4444_4444};
    vt[27] = '{0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h4444_4444};

    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    step();
    step();
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_if_valid", {31'h0, if_id_valid}, 32'h0);
    check("rst_if_pc", if_id_pc, 32'h0);
    check("rst_instr", if_id_instruction, NOP);
    check("rst_opcode", {25'h0, opcode}, 32'h13);
    check("rst_rd", {27'h0, rd}, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("post_rst_addr", imem_req_addr, 32'h0);

    for (int i = 0; i < 28; i++) begin
      cur = i;
      drive(vt[i].rdy, vt[i].rv, vt[i].data, vt[i].stall, vt[i].redir, vt[i].rpc);
      step();
      check("req_valid", {31'h0, imem_req_valid}, {31'h0, vt[i].e_req});
      check("req_addr", imem_req_addr, vt[i].e_addr);
      check("if_valid", {31'h0, if_id_valid}, {31'h0, vt[i].e_ifv});
      check("if_instr", if_id_instruction, vt[i].e_instr);
      if (vt[i].chk_pc) check("if_pc", if_id_pc, vt[i].e_pc);
      check("opcode", {25'h0, opcode}, {25'h0, vt[i].e_instr[6:0]});
      check("rd", {27'h0, rd}, {27'h0, vt[i].e_instr[11:7]});
      check("funct3", {29'h0, funct3}, {29'h0, vt[i].e_instr[14:12]});
      check("rs1", {27'h0, rs1}, {27'h0, vt[i].e_instr[19:15]});
      check("rs2", {27'h0, rs2}, {27'h0, vt[i].e_instr[24:20]});
      check("funct7", {25'h0, funct7}, {25'h0, vt[i].e_instr[31:25]});
    end

    // T6: reset while holding a stalled word
    cur = 100;
    rst = 1'b1;
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    step();
    check("t6_if_valid", {31'h0, if_id_valid}, 32'h0);
    check("t6_instr", if_id_instruction, NOP);
    check("t6_if_pc", if_id_pc, 32'h0);
    check("t6_req_in_rst", {31'h0, imem_req_valid}, 32'h0);
    rst = 1'b0;
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    #1;
    check("t6_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("t6_req_addr", imem_req_addr, 32'h0);
    step();
    check("t6_wait", {31'h0, imem_req_valid}, 32'h0);
    drive(0, 1, 32'h6666_6666, 0, 0, 32'h0);
    step();
    check("t6_load_valid", {31'h0, if_id_valid}, 32'h1);
    check("t6_load_pc", if_id_pc, 32'h0);
    check("t6_load_instr", if_id_instruction, 32'h6666_6666);
    check("t6_next_addr", imem_req_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
